// File: rtl/fc_pkg.sv
// Shared definitions for the final fully-connected layer.
// Holds the scheduler state encoding and the default layer geometry.
// The label-prediction scheduler uses the same geometry, so its scan
// range matches OUT_BASE..OUT_BASE+OUT_LEN-1.
package fc_pkg;

  localparam int unsigned FC_IN_LEN   = 16;
  localparam int unsigned FC_OUT_LEN  = 10;
  localparam int unsigned FC_OUT_BASE = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_MAC   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } fc_state_e;

endpackage

// File: rtl/fc_layer_scheduler.sv
// Control FSM for the final fully-connected layer.
// On start it computes OUT_LEN scores. For each neuron it clears the
// external MAC, streams IN_LEN feature/weight reads into it, and then
// writes the MAC result to picture memory at OUT_BASE + neuron.
//
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   start             begin the layer; only sampled in IDLE
//   MAC_rst_n         synchronous clear of the MAC accumulator (low active)
//   MAC_en            MAC accumulates the current feature x weight
//   picture_mem_addr  shared read/write picture memory address
//   picture_mem_we    write the MAC result to picture_mem_addr
//   weight_mem_addr   weight memory read address
//   done              one-cycle pulse after the last score is written
module fc_layer_scheduler
  import fc_pkg::*;
#(
  parameter int unsigned ADDR_BIT   = 10,
  parameter int unsigned W_ADDR_BIT = 8,
  parameter int unsigned IN_LEN     = FC_IN_LEN,
  parameter int unsigned OUT_LEN    = FC_OUT_LEN,
  parameter int unsigned OUT_BASE   = FC_OUT_BASE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  MAC_rst_n,
  output logic                  MAC_en,
  output logic [ADDR_BIT-1:0]   picture_mem_addr,
  output logic                  picture_mem_we,
  output logic [W_ADDR_BIT-1:0] weight_mem_addr,
  output logic                  done
);

  localparam int unsigned JW = (IN_LEN  > 1) ? $clog2(IN_LEN)  : 1;
  localparam int unsigned OW = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;

  localparam logic [JW-1:0]         J_LAST  = JW'(IN_LEN - 1);
  localparam logic [OW-1:0]         O_LAST  = OW'(OUT_LEN - 1);
  localparam logic [W_ADDR_BIT-1:0] W_STEP  = W_ADDR_BIT'(IN_LEN);
  localparam logic [ADDR_BIT-1:0]   OUT_ADR = ADDR_BIT'(OUT_BASE);

  fc_state_e             state_q, state_d;
  logic [JW-1:0]         j_q, j_d;
  logic [OW-1:0]         o_q, o_d;
  // Running o*IN_LEN, advanced once per neuron instead of multiplying.
  logic [W_ADDR_BIT-1:0] wbase_q, wbase_d;
  logic                  mac_en_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      j_q      <= '0;
      o_q      <= '0;
      wbase_q  <= '0;
      mac_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      j_q      <= j_d;
      o_q      <= o_d;
      wbase_q  <= wbase_d;
      // Memory read data arrives one cycle after the MAC-state address,
      // so the enable trails the MAC state by exactly one cycle.
      mac_en_q <= (state_q == ST_MAC);
    end
  end

  assign MAC_en = mac_en_q;

  always_comb begin
    state_d          = state_q;
    j_d              = j_q;
    o_d              = o_q;
    wbase_d          = wbase_q;
    MAC_rst_n        = 1'b1;
    picture_mem_addr = '0;
    picture_mem_we   = 1'b0;
    weight_mem_addr  = '0;
    done             = 1'b0;

    case (state_q)
      ST_IDLE: begin
        j_d     = '0;
        o_d     = '0;
        wbase_d = '0;
        if (start) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        MAC_rst_n = 1'b0;
        j_d       = '0;
        state_d   = ST_MAC;
      end
      ST_MAC: begin
        picture_mem_addr = ADDR_BIT'(j_q);
        weight_mem_addr  = wbase_q + W_ADDR_BIT'(j_q);
        if (j_q == J_LAST) begin
          j_d     = '0;
          state_d = ST_DRAIN;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        picture_mem_we   = 1'b1;
        picture_mem_addr = OUT_ADR + ADDR_BIT'(o_q);
        if (o_q == O_LAST) begin
          state_d = ST_DONE;
        end else begin
          o_d     = o_q + 1'b1;
          wbase_d = wbase_q + W_STEP;
          state_d = ST_CLEAR;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        o_d     = '0;
        wbase_d = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fc_layer_scheduler.sv
// Bench for fc_layer_scheduler: memory and MAC model around the DUT,
// expected events queued by the stimulus, checked by a monitor.
module tb_fc_layer_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       MAC_rst_n;
  logic       MAC_en;
  logic [9:0] picture_mem_addr;
  logic       picture_mem_we;
  logic [7:0] weight_mem_addr;
  logic       done;

  always #5 clk = ~clk;

  fc_layer_scheduler #(
    .ADDR_BIT  (10),
    .W_ADDR_BIT(8),
    .IN_LEN    (16),
    .OUT_LEN   (10),
    .OUT_BASE  (16)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .MAC_rst_n       (MAC_rst_n),
    .MAC_en          (MAC_en),
    .picture_mem_addr(picture_mem_addr),
    .picture_mem_we  (picture_mem_we),
    .weight_mem_addr (weight_mem_addr),
    .done            (done)
  );

  int cnt  = 0;
  int base = 0;
  always @(posedge clk) cnt <= cnt + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory and MAC model: 1-cycle synchronous reads, accumulator.
  logic [31:0] pmem [0:1023];
  logic [31:0] wmem [0:255];
  logic [31:0] pd, wd, acc;

  always @(posedge clk) begin
    pd <= pmem[picture_mem_addr];
    wd <= wmem[weight_mem_addr];
    if (!MAC_rst_n)  acc <= 32'd0;
    else if (MAC_en) acc <= acc + pd * wd;
  end

  task automatic load_pattern(input int p);
    for (int i = 0; i < 1024; i++) pmem[i] = 32'd0;
    for (int i = 0; i < 256; i++)  wmem[i] = 32'd0;
    for (int j = 0; j < 16; j++) pmem[j] = (p == 0) ? 32'd1 : 32'(j + 1);
    for (int o = 0; o < 10; o++)
      for (int j = 0; j < 16; j++)
        wmem[o*16 + j] = (p == 0) ? 32'(o) : 32'(o + j);
  endtask

  // Pattern 0: sum of 16 ones times o = 16*o.
  // Pattern 1: sum (j+1)(o+j) = 136*o + 1360.
  function automatic int exp_score(input int p, input int k);
    return (p == 0) ? 16 * k : 136 * k + 1360;
  endfunction

  typedef struct { int cyc; int addr; int data; } wr_t;
  typedef struct { int cyc; int pa;   int wa;   } adr_t;

  int   q_clr  [$];
  int   q_done [$];
  wr_t  q_wr   [$];
  adr_t q_adr  [$];
  int   en_cnt = 0;

  task automatic push_run(input int p, input int off);
    wr_t  w;
    adr_t a;
    for (int k = 0; k < 10; k++) begin
      q_clr.push_back(1 + k*19 + off);
      w.cyc  = (k + 1) * 19 + off;
      w.addr = 16 + k;
      w.data = exp_score(p, k);
      q_wr.push_back(w);
    end
    q_done.push_back(191 + off);
    // Neuron 3 occupies cycles 58..76; its MAC cycles are 59..74.
    for (int j = 0; j < 16; j++) begin
      a.cyc = 59 + j + off;
      a.pa  = j;
      a.wa  = 48 + j;
      q_adr.push_back(a);
    end
  endtask

  function automatic longint outs();
    return {42'd0, MAC_rst_n, MAC_en, picture_mem_we, done,
            picture_mem_addr, weight_mem_addr};
  endfunction

  localparam longint IDLE_V = 64'd1 << 21;

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    int   rel;
    wr_t  w;
    adr_t a;
    forever begin
      @(posedge clk);
      #1;
      rel = cnt - base;
      if (MAC_en) en_cnt++;
      if (!MAC_rst_n) begin
        if (q_clr.size() == 0) check("clr_unexpected_cycle", rel, -1);
        else                   check("clr_cycle", rel, q_clr.pop_front());
      end
      if (picture_mem_we) begin
        if (q_wr.size() == 0) begin
          check("write_unexpected_cycle", rel, -1);
        end else begin
          w = q_wr.pop_front();
          check("write_cycle", rel, w.cyc);
          check("write_addr", picture_mem_addr, w.addr);
          check("write_score", acc, w.data);
        end
      end
      if (done) begin
        if (q_done.size() == 0) check("done_unexpected_cycle", rel, -1);
        else                    check("done_cycle", rel, q_done.pop_front());
      end
      if (q_adr.size() > 0 && q_adr[0].cyc == rel) begin
        a = q_adr.pop_front();
        check("n3_picture_addr", picture_mem_addr, a.pa);
        check("n3_weight_addr", weight_mem_addr, a.wa);
      end
    end
  end

  function automatic int q_left();
    return q_clr.size() + q_done.size() + q_wr.size() + q_adr.size();
  endfunction

  // Call at a falling edge; returns at the falling edge of cycle 1.
  int en_base = 0;
  task automatic launch(input logic hold);
    base    = cnt;
    en_base = en_cnt;
    start   = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    load_pattern(0);
    #1 rst_n = 1'b0;
    #20;
    check("reset_outputs", outs(), IDLE_V);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check("idle_outputs", outs(), IDLE_V);
    end

    // Single pulsed run, plus a stray start at cycle 50 that must be ignored.
    push_run(0, 0);
    launch(1'b0);
    repeat (49) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (149) @(negedge clk);
    check("run1_mac_en_count", en_cnt - en_base, 160);
    check("run1_queue_left", q_left(), 0);

    // Start held high: second run begins at cycle 193.
    load_pattern(1);
    push_run(1, 0);
    push_run(1, 192);
    launch(1'b1);
    repeat (199) @(negedge clk);
    start = 1'b0;
    repeat (190) @(negedge clk);
    check("held_mac_en_count", en_cnt - en_base, 320);
    check("held_queue_left", q_left(), 0);

    // Reset in cycle 100, then a complete fresh run.
    load_pattern(0);
    push_run(0, 0);
    launch(1'b0);
    repeat (99) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrun_reset_outputs", outs(), IDLE_V);
    q_clr.delete();
    q_done.delete();
    q_wr.delete();
    q_adr.delete();
    repeat (3) @(negedge clk);
    check("held_reset_outputs", outs(), IDLE_V);
    rst_n = 1'b1;
    @(negedge clk);
    push_run(0, 0);
    launch(1'b0);
    repeat (199) @(negedge clk);
    check("rerun_mac_en_count", en_cnt - en_base, 160);
    check("rerun_queue_left", q_left(), 0);
    check("rerun_final_idle", outs(), IDLE_V);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
